// File: rtl/seq_pattern_finder.sv
`timescale 1ns/1ps
// Serial pattern detector: shifts accepted bits into a PAT_W-bit history and
// pulses match when the history equals PATTERN, with a saturating match counter.
module seq_pattern_finder #(
    parameter int unsigned       PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(4'b1101),
    parameter int unsigned       CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             overlap,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             sat,
    output logic [PAT_W-1:0] window
);

    localparam int unsigned       FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
    logic [PAT_W-1:0]   window_q, window_d, win_shift;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               match_q, match_d;
    logic               sat_q, sat_d;
    logic               accept;
    logic               hit;

    // Detection is judged on the post-shift window and post-increment fill.
    assign accept    = in_valid & ~clear;
    assign win_shift = {window_q[PAT_W-2:0], in_bit};
    assign fill_inc  = (state_q == ARMED) ? FILL_FULL : fill_q + FILL_W'(1);
    assign hit       = accept && (win_shift == PATTERN) && (fill_inc == FILL_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILLING;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = FILLING;
        end else if (accept) begin
            case (state_q)
                FILLING: if (fill_inc == FILL_FULL && !(hit && !overlap)) state_d = ARMED;
                ARMED:   if (hit && !overlap) state_d = FILLING;
                default: state_d = FILLING;
            endcase
        end
    end

    // Non-overlap detection restarts the fill but keeps the shifted window.
    always_comb begin
        window_d = window_q;
        fill_d   = fill_q;
        count_d  = count_q;
        sat_d    = sat_q;
        match_d  = 1'b0;
        if (clear) begin
            window_d = '0;
            fill_d   = '0;
            count_d  = '0;
            sat_d    = 1'b0;
        end else if (accept) begin
            window_d = win_shift;
            fill_d   = (hit && !overlap) ? '0 : fill_inc;
            if (hit) begin
                match_d = 1'b1;
                if (count_q == CNT_MAX) begin
                    sat_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_q <= '0;
            fill_q   <= '0;
            count_q  <= '0;
            sat_q    <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
            count_q  <= count_d;
            sat_q    <= sat_d;
            match_q  <= match_d;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign sat         = sat_q;
    assign window      = window_q;

endmodule

// File: tb/tb_seq_pattern_finder.sv
`timescale 1ns/1ps
// Scoreboard bench for seq_pattern_finder: one instance with an 8-bit counter
// and one with a 2-bit counter share stimulus; match is checked every cycle.
module tb_seq_pattern_finder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       overlap = 1'b0;
    logic       clear = 1'b0;
    logic       match, sat, match2, sat2;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic [3:0] win, win2;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];
    bit e;

    seq_pattern_finder #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .overlap(overlap), .clear(clear), .match(match), .match_count(cnt),
        .sat(sat), .window(win)
    );

    seq_pattern_finder #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .overlap(overlap), .clear(clear), .match(match2), .match_count(cnt2),
        .sat(sat2), .window(win2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; em is the hand-computed match for the following cycle.
    task automatic drive(input logic v, input logic b, input logic o, input logic c, input bit em);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        overlap  = o;
        clear    = c;
        @(posedge clk);
        exp_q.push_back(em);
    endtask

    task automatic send_n(input logic [15:0] bits, input int n, input logic o, input logic [15:0] ems);
        for (int i = n - 1; i >= 0; i--) begin
            drive(1'b1, bits[i], o, 1'b0, ems[i]);
        end
    endtask

    task automatic do_clear();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents match, compare against the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("match", 32'(match), 32'(e));
            chk("match_cnt2", 32'(match2), 32'(e));
        end else if (match || match2) begin
            chk("unexpected_match", 32'({match, match2}), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_window", 32'(win), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single 1101
        send_n(16'b1101, 4, 1'b1, 16'b0001);
        #1;
        chk("t1_count", 32'(cnt), 32'd1);
        chk("t1_window", 32'(win), 32'hd);
        do_clear();
        #1;
        chk("clr_count", 32'(cnt), 32'd0);
        chk("clr_window", 32'(win), 32'd0);

        // 1101101 with overlap
        send_n(16'b1101101, 7, 1'b1, 16'b0001001);
        #1;
        chk("ovl_count", 32'(cnt), 32'd2);
        chk("ovl_window", 32'(win), 32'hd);
        do_clear();

        // 1101101 without overlap
        send_n(16'b1101101, 7, 1'b0, 16'b0001000);
        #1;
        chk("novl_count", 32'(cnt), 32'd1);
        chk("novl_window", 32'(win), 32'hd);
        do_clear();

        // 1101 with idle gaps
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("idle_count", 32'(cnt), 32'd1);
        chk("idle_window", 32'(win), 32'hd);
        do_clear();

        // Five non-overlapping 1101s: 2-bit counter saturates
        for (int p = 1; p <= 5; p++) begin
            send_n(16'b1101, 4, 1'b0, 16'b0001);
            #1;
            if (p == 3) begin
                chk("sat3_count2", 32'(cnt2), 32'd3);
                chk("sat3_sat2", 32'(sat2), 32'd0);
                chk("sat3_count", 32'(cnt), 32'd3);
            end
            if (p == 4) begin
                chk("sat4_count2", 32'(cnt2), 32'd3);
                chk("sat4_sat2", 32'(sat2), 32'd1);
            end
        end
        chk("sat5_count", 32'(cnt), 32'd5);
        chk("sat5_sat", 32'(sat), 32'd0);
        chk("sat5_count2", 32'(cnt2), 32'd3);
        chk("sat5_sat2", 32'(sat2), 32'd1);
        do_clear();
        #1;
        chk("satclr_count2", 32'(cnt2), 32'd0);
        chk("satclr_sat2", 32'(sat2), 32'd0);

        // clear coincident with the completing bit
        send_n(16'b110, 3, 1'b1, 16'b000);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("clrhit_count", 32'(cnt), 32'd0);
        chk("clrhit_window", 32'(win), 32'd0);

        // Asynchronous reset mid-pattern
        send_n(16'b1101110, 7, 1'b1, 16'b0001000);
        #1;
        chk("pre_rst_count", 32'(cnt), 32'd1);
        chk("pre_rst_window", 32'(win), 32'he);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_match", 32'(match), 32'd0);
        chk("async_count", 32'(cnt), 32'd0);
        chk("async_sat", 32'(sat2), 32'd0);
        chk("async_window", 32'(win), 32'd0);
        chk("async_count2", 32'(cnt2), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("post_rst_count", 32'(cnt), 32'd0);
        chk("post_rst_window", 32'(win), 32'h1);

        repeat (3) @(negedge clk);
        #1;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_pattern_finder.md
SEQ_PATTERN_FINDER -- requirements
Module: seq_pattern_finder

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..32.
REQ-002 Parameter PATTERN, default 4'b1101: target sequence; MSB is the oldest bit and LSB is the newest bit.
REQ-003 Parameter CNT_W, default 8: width of the match counter, legal range 1..32.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port in_valid, input, 1 bit: in_bit is sampled only in cycles where in_valid=1.
REQ-007 Port in_bit, input, 1 bit: serial data bit.
REQ-008 Port overlap, input, 1 bit: 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-009 Port clear, input, 1 bit: synchronous clear of window, fill count, counter and sat.
REQ-010 Port match, output, 1 bit: registered single-cycle pulse on detection.
REQ-011 Port match_count, output, CNT_W bits: number of detections, saturating.
REQ-012 Port sat, output, 1 bit: sticky flag, set when match_count is saturated and a further match occurs.
REQ-013 Port window, output, PAT_W bits: current shift history; LSB is the newest bit.

Function
REQ-014 On each accepted bit (in_valid=1, clear=0): window shall become {window[PAT_W-2:0], in_bit}.
REQ-015 An internal fill counter shall count accepted bits and saturate at PAT_W.
REQ-016 A detection occurs on an accepted bit when both conditions hold after the shift:
- the new window equals PATTERN;
- the fill count after increment equals PAT_W.
REQ-017 match shall be 1 in the cycle immediately after the accepted bit that completes the detection (1-cycle latency), and 0 in all other cycles.
REQ-018 overlap=1: on detection, fill shall remain at PAT_W, so the bits of a detected pattern can contribute to the next detection.
REQ-019 overlap=0: on detection, fill shall reset to 0 and window shall remain shifted, so the next detection needs PAT_W fresh accepted bits.
REQ-020 overlap is sampled per accepted bit; changing it mid-stream affects only subsequent detections.
REQ-021 Cycles with in_valid=0 shall leave window, fill, match_count and sat unchanged, and match shall be 0 in the following cycle.
REQ-022 On detection, match_count shall increment by 1 if it is below 2^CNT_W-1.
REQ-023 On detection with match_count already at 2^CNT_W-1, match_count shall hold, sat shall go to 1, and match shall still pulse.
REQ-024 sat shall remain 1 until clear or reset.
REQ-025 clear=1 shall zero window, fill, match_count, sat and the match register on the next edge.
REQ-026 clear has priority over in_valid in the same cycle: the bit is discarded and no detection occurs.
REQ-027 The FSM shall have two states:
- FILLING (fill<PAT_W), exits to ARMED when fill reaches PAT_W;
- ARMED (fill==PAT_W), returns to FILLING on non-overlap detection or clear, otherwise stays.
REQ-028 All outputs shall be driven directly from registers; there is no combinational path from inputs to outputs.

Reset
REQ-029 rst_n=0 shall asynchronously force match=0, match_count=0, sat=0, window=0 and fill=0 (state FILLING), independent of clk.
REQ-030 Deassertion of rst_n shall take effect at the first rising clk edge with rst_n=1; bits presented while rst_n=0 are lost.
REQ-031 A reset mid-pattern shall discard partial history; a pattern straddling the reset shall not be detected.

Verification (PAT_W=4, PATTERN=1101, CNT_W=8 unless stated)
REQ-032 Accepted bits 1,1,0,1 on consecutive cycles -> match=1 for exactly the one cycle after the 4th bit; match_count=1; window=4'b1101.
REQ-033 Stream 1,1,0,1,1,0,1 -> overlap=1: matches after bits 4 and 7, match_count=2; overlap=0: match after bit 4 only, match_count=1.
REQ-034 Bits 1,1,0,1 with in_valid=0 idle cycles between them -> a single match one cycle after the final accepted bit; no match in idle cycles.
REQ-035 CNT_W=2, overlap=0, stream of five 1101 patterns -> match_count reaches 3 after the 3rd pattern, sat=1 after the 4th, five match pulses total; then clear=1 -> match_count=0, sat=0.
REQ-036 clear=1 in the same cycle as the 4th bit of 1101 -> no match pulse; match_count=0; window=0.
REQ-037 Drive 1,1,0, assert rst_n=0 between clock edges, release, then drive 1 -> all outputs 0 immediately on reset assertion; no match; match_count=0.
